// File: rtl/mul16_seq_ctrl.sv
// Unsigned 16x16->32 multiply sequenced as four byte-slice products on a shared external 8x8 unit.
// Define ZERO_SKIP_EN to send ops with a zero operand straight to the result without issuing.
module mul16_seq_ctrl #(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mul_vld,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  mul_a_q, mul_a_d;
    logic [7:0]  mul_b_q, mul_b_d;
    logic [31:0] acc_q, acc_d;

    logic [4:0]  issueShift;
    logic        tagValid;
    logic [4:0]  tagShift;

    // Pass p uses a-slice p[1] and b-slice p[0], so the weight is 8*(p[1]+p[0]).
    assign issueShift = {pass_q[1] & pass_q[0], pass_q[1] ^ pass_q[0], 3'b000};

    generate
        if (MUL_LAT == 0) begin : g_no_pipe
            assign tagValid = mul_vld;
            assign tagShift = issueShift;
        end else begin : g_tag_pipe
            logic       tagVld_q [MUL_LAT];
            logic [4:0] tagSh_q  [MUL_LAT];

            // Tags travel in lockstep with the external multiplier pipeline.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < MUL_LAT; i++) begin
                        tagVld_q[i] <= 1'b0;
                        tagSh_q[i]  <= '0;
                    end
                end else begin
                    tagVld_q[0] <= mul_vld;
                    tagSh_q[0]  <= issueShift;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        tagVld_q[i] <= tagVld_q[i-1];
                        tagSh_q[i]  <= tagSh_q[i-1];
                    end
                end
            end

            assign tagValid = tagVld_q[MUL_LAT-1];
            assign tagShift = tagSh_q[MUL_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
            drain_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        drain_d = drain_q;
        a_d     = a_q;
        b_d     = b_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;

        if (tagValid) begin
            acc_d = acc_q + ({16'b0, mul_p} << tagShift);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    pass_d  = '0;
                    mul_a_d = in_a[7:0];
                    mul_b_d = in_b[7:0];
`ifdef ZERO_SKIP_EN
                    state_d = (in_a == 16'd0 || in_b == 16'd0) ? DONE : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                pass_d = pass_q + 2'd1;
                if (pass_q == 2'd3) begin
                    if (MUL_LAT > 0) begin
                        state_d = DRAIN;
                        drain_d = 2'(MUL_LAT - 1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    // Slices are registered one cycle ahead of the pass that uses them.
                    mul_a_d = pass_d[1] ? a_q[15:8] : a_q[7:0];
                    mul_b_d = pass_d[0] ? b_q[15:8] : b_q[7:0];
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign mul_vld   = (state_q == ISSUE);
    assign out_valid = (state_q == DONE);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_p     = acc_q;

endmodule
